// File: rtl/hazard_ctrl_unit.sv
// Hazard/forwarding controller for a 5-stage pipe: load-use stalls, redirect flushes, EX write gating.
// Optional HAZ_PERF_CNT_EN adds saturating stall_cnt/flush_cnt performance counters.
module hazard_ctrl_unit #(
  parameter int REG_AW      = 3,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_rf_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_rf_we,
  input  logic              redirect,
  input  logic              mc_busy,
  input  logic              ex_rf_we_in,
  input  logic              ex_mem_we_in,
  output logic              stall,
  output logic              flush_if_id,
  output logic              bubble_ex,
  output logic              ex_rf_we,
  output logic              ex_mem_we,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  localparam int LCNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
  localparam logic [FLUSH_DEPTH-1:0] SR_LOAD = {FLUSH_DEPTH{1'b1}} >> 1;

  if (LOAD_LAT < 1 || FLUSH_DEPTH < 1 || CNT_W < 1) begin : g_param_check
    $error("hazard_ctrl_unit: LOAD_LAT, FLUSH_DEPTH and CNT_W must all be >= 1");
  end

  typedef enum logic {S_IDLE, S_LU_STALL} state_t;

  state_t                 state_q;
  logic [LCNT_W-1:0]      lat_cnt_q;
  logic [FLUSH_DEPTH-1:0] flush_sr_q;
  logic                   ex_kill_q;
  logic                   ex_kill_d;

  logic rs_ex_match, rt_ex_match, lu_hit, lu_stall;
  logic stall_c, bubble_c, flush_c;

  // Register 0 is hard-wired, so it never creates a dependency.
  assign rs_ex_match = id_rs_used && (id_rs != '0) && (id_rs == ex_rd);
  assign rt_ex_match = id_rt_used && (id_rt != '0) && (id_rt == ex_rd);
  assign lu_hit      = (state_q == S_IDLE) && ex_is_load && (rs_ex_match || rt_ex_match);
  assign lu_stall    = lu_hit || (state_q == S_LU_STALL);

  assign stall_c  = !rst && (mc_busy || (lu_stall && !redirect));
  assign bubble_c = stall_c && !mc_busy;
  assign flush_c  = !rst && (redirect || (flush_sr_q != '0));
  assign ex_kill_d = (flush_c || bubble_c) && !mc_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lat_cnt_q  <= '0;
      flush_sr_q <= '0;
      ex_kill_q  <= 1'b0;
    end else begin
      if (redirect) begin
        state_q    <= S_IDLE;
        lat_cnt_q  <= '0;
        flush_sr_q <= SR_LOAD;
      end else begin
        flush_sr_q <= flush_sr_q >> 1;
        case (state_q)
          S_IDLE: begin
            if (lu_hit && (LOAD_LAT > 1)) begin
              state_q   <= S_LU_STALL;
              lat_cnt_q <= LCNT_W'(LOAD_LAT - 1);
            end
          end
          S_LU_STALL: begin
            lat_cnt_q <= lat_cnt_q - LCNT_W'(1);
            if (lat_cnt_q == LCNT_W'(1)) begin
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
      // A frozen pipe keeps the same instruction in EX, so its kill status must persist.
      if (!mc_busy) begin
        ex_kill_q <= ex_kill_d;
      end
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src, input logic used);
    logic [1:0] sel;
    sel = 2'b00;
    if (used && (src != '0)) begin
      if (mem_rf_we && (mem_rd == src)) begin
        sel = 2'b01;
      end else if (wb_rf_we && (wb_rd == src)) begin
        sel = 2'b10;
      end
    end
    return sel;
  endfunction

  assign fwd_a       = fwd_sel(id_rs, id_rs_used);
  assign fwd_b       = fwd_sel(id_rt, id_rt_used);
  assign stall       = stall_c;
  assign bubble_ex   = bubble_c;
  assign flush_if_id = flush_c;
  assign ex_rf_we    = !rst && ex_rf_we_in && !ex_kill_q;
  assign ex_mem_we   = !rst && ex_mem_we_in && !ex_kill_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bubble_c && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_c && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: two instances (LOAD_LAT=1/FLUSH_DEPTH=1 and LOAD_LAT=3/FLUSH_DEPTH=2)
// share one stimulus stream; each task checks its own hand-computed expectations.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic       id_rs_used, id_rt_used, ex_is_load, mem_rf_we, wb_rf_we;
  logic       redirect, mc_busy, ex_rf_we_in, ex_mem_we_in;

  logic       u1_stall, u1_flush, u1_bub, u1_rfwe, u1_memwe;
  logic       u3_stall, u3_flush, u3_bub, u3_rfwe, u3_memwe;
  logic [1:0] u1_fwd_a, u1_fwd_b, u3_fwd_a, u3_fwd_b;
`ifdef HAZ_PERF_CNT_EN
  logic [7:0] u1_scnt, u1_fcnt, u3_scnt, u3_fcnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_AW(3), .LOAD_LAT(1), .FLUSH_DEPTH(1), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .mem_rd(mem_rd),
    .mem_rf_we(mem_rf_we), .wb_rd(wb_rd), .wb_rf_we(wb_rf_we), .redirect(redirect),
    .mc_busy(mc_busy), .ex_rf_we_in(ex_rf_we_in), .ex_mem_we_in(ex_mem_we_in),
    .stall(u1_stall), .flush_if_id(u1_flush), .bubble_ex(u1_bub), .ex_rf_we(u1_rfwe),
    .ex_mem_we(u1_memwe), .fwd_a(u1_fwd_a), .fwd_b(u1_fwd_b)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(u1_scnt), .flush_cnt(u1_fcnt)
`endif
  );

  hazard_ctrl_unit #(.REG_AW(3), .LOAD_LAT(3), .FLUSH_DEPTH(2), .CNT_W(8)) u3 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used),
    .id_rt_used(id_rt_used), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .mem_rd(mem_rd),
    .mem_rf_we(mem_rf_we), .wb_rd(wb_rd), .wb_rf_we(wb_rf_we), .redirect(redirect),
    .mc_busy(mc_busy), .ex_rf_we_in(ex_rf_we_in), .ex_mem_we_in(ex_mem_we_in),
    .stall(u3_stall), .flush_if_id(u3_flush), .bubble_ex(u3_bub), .ex_rf_we(u3_rfwe),
    .ex_mem_we(u3_memwe), .fwd_a(u3_fwd_a), .fwd_b(u3_fwd_b)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt(u3_scnt), .flush_cnt(u3_fcnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; id_rs_used = 0; id_rt_used = 0;
    ex_rd = '0; ex_is_load = 0; mem_rd = '0; mem_rf_we = 0; wb_rd = '0; wb_rf_we = 0;
    redirect = 0; mc_busy = 0; ex_rf_we_in = 0; ex_mem_we_in = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    id_rs = 3; id_rs_used = 1; ex_rd = 3; ex_is_load = 1;
    redirect = 1; mc_busy = 1; ex_rf_we_in = 1; ex_mem_we_in = 1;
    #1;
    checks++;
    if ({u1_stall, u3_stall, u1_flush, u3_flush, u1_bub, u3_bub} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: stall/flush/bubble=%b required 000000",
               {u1_stall, u3_stall, u1_flush, u3_flush, u1_bub, u3_bub});
    end
    checks++;
    if ({u1_rfwe, u3_rfwe, u1_memwe, u3_memwe} !== 4'b0) begin
      failures++;
      $display("FAIL reset_we: we=%b required 0000", {u1_rfwe, u3_rfwe, u1_memwe, u3_memwe});
    end
    tick();
    clear_inputs();
    ex_rf_we_in = 1; ex_mem_we_in = 1;
    tick();
    rst = 0;
    #1;
    checks++;
    if ({u1_stall, u3_stall, u1_flush, u3_flush, u1_bub, u3_bub} !== 6'b0) begin
      failures++;
      $display("FAIL post_reset_ctrl: got %b required 000000",
               {u1_stall, u3_stall, u1_flush, u3_flush, u1_bub, u3_bub});
    end
    checks++;
    if ({u1_rfwe, u3_rfwe, u1_memwe, u3_memwe} !== 4'b1111) begin
      failures++;
      $display("FAIL post_reset_we: got %b required 1111", {u1_rfwe, u3_rfwe, u1_memwe, u3_memwe});
    end
    $display("txn reset done");
    tick();
  endtask

  task automatic test_load_use();
    bit [0:4] s1 = 5'b10000;
    bit [0:4] s3 = 5'b11100;
    bit [0:4] w1 = 5'b10111;
    bit [0:4] w3 = 5'b10001;
    clear_inputs();
    ex_rf_we_in = 1; ex_mem_we_in = 1;
    id_rs = 3; id_rs_used = 1;
    for (int i = 0; i < 5; i++) begin
      ex_rd = (i == 0) ? 3'd3 : 3'd0;
      ex_is_load = (i == 0);
      #1;
      checks++;
      if ({u1_stall, u1_bub, u3_stall, u3_bub} !== {s1[i], s1[i], s3[i], s3[i]}) begin
        failures++;
        $display("FAIL lu_stall[%0d]: stall/bub u1,u3=%b required %b", i,
                 {u1_stall, u1_bub, u3_stall, u3_bub}, {s1[i], s1[i], s3[i], s3[i]});
      end
      checks++;
      if ({u1_rfwe, u1_memwe, u3_rfwe, u3_memwe} !== {w1[i], w1[i], w3[i], w3[i]}) begin
        failures++;
        $display("FAIL lu_we[%0d]: we u1,u3=%b required %b", i,
                 {u1_rfwe, u1_memwe, u3_rfwe, u3_memwe}, {w1[i], w1[i], w3[i], w3[i]});
      end
      $display("txn load_use cycle %0d stall1=%b stall3=%b", i, u1_stall, u3_stall);
      tick();
    end
  endtask

  task automatic test_rt_and_r0();
    bit [0:3] s1 = 4'b1000;
    bit [0:3] s3 = 4'b1110;
    clear_inputs();
    id_rs = 2; id_rs_used = 1; id_rt = 5; id_rt_used = 1;
    for (int i = 0; i < 4; i++) begin
      ex_rd = (i == 0) ? 3'd5 : 3'd0;
      ex_is_load = (i == 0);
      #1;
      checks++;
      if ({u1_stall, u3_stall} !== {s1[i], s3[i]}) begin
        failures++;
        $display("FAIL rt_match[%0d]: stall u1,u3=%b required %b", i, {u1_stall, u3_stall}, {s1[i], s3[i]});
      end
      tick();
    end
    id_rs = 0; id_rt = 0; ex_rd = 0; ex_is_load = 1;
    #1;
    checks++;
    if ({u1_stall, u3_stall} !== 2'b00) begin
      failures++;
      $display("FAIL r0_no_stall: stall u1,u3=%b required 00", {u1_stall, u3_stall});
    end
    tick();
    id_rs = 4; id_rt = 4; id_rs_used = 0; id_rt_used = 0; ex_rd = 4; ex_is_load = 1;
    #1;
    checks++;
    if ({u1_stall, u3_stall} !== 2'b00) begin
      failures++;
      $display("FAIL unused_no_stall: stall u1,u3=%b required 00", {u1_stall, u3_stall});
    end
    $display("txn rt_and_r0 done");
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_redirect();
    bit [0:6] r   = 7'b1001100;
    bit [0:6] f1  = 7'b1001100;
    bit [0:6] f3  = 7'b1101110;
    bit [0:6] we1 = 7'b1011001;
    bit [0:6] we3 = 7'b1001000;
    clear_inputs();
    ex_rf_we_in = 1; ex_mem_we_in = 1;
    for (int i = 0; i < 7; i++) begin
      redirect = r[i];
      #1;
      checks++;
      if ({u1_flush, u3_flush, u1_stall, u3_stall, u1_bub, u3_bub} !== {f1[i], f3[i], 4'b0000}) begin
        failures++;
        $display("FAIL flush[%0d]: flush1,flush3,stall,bub=%b required %b", i,
                 {u1_flush, u3_flush, u1_stall, u3_stall, u1_bub, u3_bub}, {f1[i], f3[i], 4'b0000});
      end
      checks++;
      if ({u1_rfwe, u1_memwe, u3_rfwe, u3_memwe} !== {we1[i], we1[i], we3[i], we3[i]}) begin
        failures++;
        $display("FAIL flush_kill[%0d]: we u1,u3=%b required %b", i,
                 {u1_rfwe, u1_memwe, u3_rfwe, u3_memwe}, {we1[i], we1[i], we3[i], we3[i]});
      end
      $display("txn redirect cycle %0d redirect=%b flush1=%b flush3=%b", i, r[i], u1_flush, u3_flush);
      tick();
    end
  endtask

  task automatic test_redirect_vs_lu();
    clear_inputs();
    id_rs = 3; id_rs_used = 1; ex_rd = 3; ex_is_load = 1; redirect = 1;
    #1;
    checks++;
    if ({u3_stall, u3_bub, u3_flush, u1_stall} !== 4'b0010) begin
      failures++;
      $display("FAIL redir_beats_lu: u3 stall,bub,flush,u1 stall=%b required 0010",
               {u3_stall, u3_bub, u3_flush, u1_stall});
    end
    tick();
    ex_is_load = 0; redirect = 0;
    #1;
    checks++;
    if (u3_stall !== 1'b0) begin
      failures++;
      $display("FAIL redir_fsm_idle: u3 stall=%b required 0", u3_stall);
    end
    tick();
    ex_is_load = 1;
    #1;
    checks++;
    if (u3_stall !== 1'b1) begin
      failures++;
      $display("FAIL lu_after_redir: u3 stall=%b required 1", u3_stall);
    end
    tick();
    ex_is_load = 0; redirect = 1;
    #1;
    checks++;
    if ({u3_stall, u3_bub} !== 2'b00) begin
      failures++;
      $display("FAIL redir_in_lu_stall: u3 stall,bub=%b required 00", {u3_stall, u3_bub});
    end
    tick();
    redirect = 0;
    #1;
    checks++;
    if (u3_stall !== 1'b0) begin
      failures++;
      $display("FAIL redir_clears_cnt: u3 stall=%b required 0", u3_stall);
    end
    $display("txn redirect_vs_lu done");
    tick();
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_mc_busy();
    clear_inputs();
    ex_rf_we_in = 1; ex_mem_we_in = 1;
    redirect = 1;
    tick();
    redirect = 0; mc_busy = 1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++;
      if ({u1_stall, u1_bub, u3_stall, u3_bub, u1_rfwe, u3_rfwe} !== 6'b101000) begin
        failures++;
        $display("FAIL mc_busy[%0d]: stall,bub u1,u3 & rfwe=%b required 101000", i,
                 {u1_stall, u1_bub, u3_stall, u3_bub, u1_rfwe, u3_rfwe});
      end
      $display("txn mc_busy cycle %0d stall1=%b bub1=%b", i, u1_stall, u1_bub);
      tick();
    end
    mc_busy = 0;
    #1;
    checks++;
    if ({u1_stall, u3_stall, u1_rfwe, u3_rfwe} !== 4'b0000) begin
      failures++;
      $display("FAIL mc_release_kill: stall,rfwe=%b required 0000", {u1_stall, u3_stall, u1_rfwe, u3_rfwe});
    end
    tick();
    #1;
    checks++;
    if ({u1_rfwe, u3_rfwe} !== 2'b11) begin
      failures++;
      $display("FAIL mc_after_release: rfwe u1,u3=%b required 11", {u1_rfwe, u3_rfwe});
    end
    tick();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    id_rs = 2; id_rs_used = 1; mem_rd = 2; mem_rf_we = 1; wb_rd = 2; wb_rf_we = 1;
    #1;
    checks++;
    if ({u1_fwd_a, u3_fwd_a} !== 4'b0101) begin
      failures++;
      $display("FAIL fwd_mem_prio: fwd_a=%b required 0101", {u1_fwd_a, u3_fwd_a});
    end
    mem_rf_we = 0;
    #1;
    checks++;
    if (u1_fwd_a !== 2'b10) begin
      failures++;
      $display("FAIL fwd_wb: fwd_a=%b required 10", u1_fwd_a);
    end
    mem_rf_we = 1; wb_rd = 6; id_rt = 6; id_rt_used = 1;
    #1;
    checks++;
    if ({u1_fwd_a, u1_fwd_b} !== 4'b0110) begin
      failures++;
      $display("FAIL fwd_split: fwd_a,fwd_b=%b required 0110", {u1_fwd_a, u1_fwd_b});
    end
    id_rt_used = 0;
    #1;
    checks++;
    if (u1_fwd_b !== 2'b00) begin
      failures++;
      $display("FAIL fwd_unused: fwd_b=%b required 00", u1_fwd_b);
    end
    id_rs = 0; mem_rd = 0; wb_rd = 0; wb_rf_we = 1;
    #1;
    checks++;
    if (u1_fwd_a !== 2'b00) begin
      failures++;
      $display("FAIL fwd_r0: fwd_a=%b required 00", u1_fwd_a);
    end
    id_rs = 7; mem_rd = 5; wb_rd = 3;
    #1;
    checks++;
    if (u1_fwd_a !== 2'b00) begin
      failures++;
      $display("FAIL fwd_nomatch: fwd_a=%b required 00", u1_fwd_a);
    end
    $display("txn forwarding done");
    tick();
  endtask

  task automatic test_reset_mid_stall();
    clear_inputs();
    id_rs = 3; id_rs_used = 1; ex_rd = 3; ex_is_load = 1;
    tick();
    ex_is_load = 0;
    #1;
    checks++;
    if (u3_stall !== 1'b1) begin
      failures++;
      $display("FAIL mid_stall_pre: u3 stall=%b required 1", u3_stall);
    end
    rst = 1;
    #1;
    checks++;
    if (u3_stall !== 1'b0) begin
      failures++;
      $display("FAIL mid_stall_in_rst: u3 stall=%b required 0", u3_stall);
    end
    tick();
    rst = 0;
    #1;
    checks++;
    if ({u3_stall, u3_bub, u3_flush} !== 3'b000) begin
      failures++;
      $display("FAIL mid_stall_abort: u3 stall,bub,flush=%b required 000", {u3_stall, u3_bub, u3_flush});
    end
`ifdef HAZ_PERF_CNT_EN
    checks++;
    if ({u1_scnt, u1_fcnt, u3_scnt, u3_fcnt} !== 32'd0) begin
      failures++;
      $display("FAIL perf_cnt_clear: counters=%h required 0", {u1_scnt, u1_fcnt, u3_scnt, u3_fcnt});
    end
`endif
    $display("txn reset_mid_stall done");
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_rt_and_r0();
    test_redirect();
    test_redirect_vs_lu();
    test_mc_busy();
    test_forwarding();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
